// File: rtl/sat_add_arb_if.sv
// ============================================================================
// Module   : sat_add_arb_if
// Purpose  : Bus bundle between two requesters, the consumer of results and
//            the sat_add_arb sequencer.
//            master : client side (drives requests, operands and ack)
//            slave  : arbiter side (drives grants and the tagged result)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sat_add_arb_if;
  logic        req0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        req1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        vld;
  logic        vld_id;
  logic [15:0] result;
  logic        sat_pos;
  logic        sat_neg;
  logic        ack;

  modport master (
    output req0, a0, b0, req1, a1, b1, ack,
    input  gnt0, gnt1, vld, vld_id, result, sat_pos, sat_neg
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, ack,
    output gnt0, gnt1, vld, vld_id, result, sat_pos, sat_neg
  );
endinterface

`default_nettype wire

// File: rtl/sat_add_arb.sv
// ============================================================================
// Module   : sat_add_arb
// Purpose  : Two-requester round-robin sequencer in front of one shared
//            16-bit saturating adder (sat_add). Captures the winner's
//            operands, computes in a single cycle and presents a registered,
//            id-tagged result held until acknowledged.
// Options  : define SAT_CNT_EN to add the CNT_W parameter and the sticky
//            per-requester saturation-event counters sat_cnt0/sat_cnt1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Shared combinational saturating adder (carry-in fixed at 0).
module sat_add (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  output logic      [15:0] sum,
  output logic             sat_pos,
  output logic             sat_neg
);
  logic [15:0] raw;

  assign raw     = a + b;
  // Overflow is only possible when both operands share a sign and the raw
  // sum's sign differs from it.
  assign sat_pos = ~a[15] & ~b[15] &  raw[15];
  assign sat_neg =  a[15] &  b[15] & ~raw[15];
  assign sum     = sat_pos ? 16'h7FFF : (sat_neg ? 16'h8000 : raw);
endmodule

module sat_add_arb
`ifdef SAT_CNT_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  wire logic          clk,
  input  wire logic          rst_n,
  sat_add_arb_if.slave       bus
`ifdef SAT_CNT_EN
  ,
  output logic [CNT_W-1:0]   sat_cnt0,
  output logic [CNT_W-1:0]   sat_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        grant_any;   // a grant is issued at this edge
  logic        grant_id;    // id of the requester being granted
  logic        rr_ptr;      // id favoured when both request (reset: req0)
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_id;

  logic [15:0] add_sum;
  logic        add_pos;
  logic        add_neg;

  // The single shared adder works on the captured operands.
  sat_add u_sat_add (
    .a       (op_a),
    .b       (op_b),
    .sum     (add_sum),
    .sat_pos (add_pos),
    .sat_neg (add_neg)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and arbitration decision; requests only count in IDLE.
  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_any = 1'b1;
          // Contention goes to the favoured id, otherwise the lone requester.
          grant_id  = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
          state_nxt = CALC;
        end
      end
      CALC: state_nxt = RESP;
      RESP: begin
        if (bus.ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant pulses, operand capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      op_a     <= 16'h0000;
      op_b     <= 16'h0000;
      op_id    <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      bus.gnt0 <= grant_any & ~grant_id;
      bus.gnt1 <= grant_any &  grant_id;
      if (grant_any) begin
        op_a   <= grant_id ? bus.a1 : bus.a0;
        op_b   <= grant_id ? bus.b1 : bus.b0;
        op_id  <= grant_id;
        // Whoever was just served loses the next tie.
        rr_ptr <= ~grant_id;
      end
    end
  end

  // Result register and valid/ack handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vld     <= 1'b0;
      bus.vld_id  <= 1'b0;
      bus.result  <= 16'h0000;
      bus.sat_pos <= 1'b0;
      bus.sat_neg <= 1'b0;
    end else begin
      if (state == CALC) begin
        bus.vld     <= 1'b1;
        bus.vld_id  <= op_id;
        bus.result  <= add_sum;
        bus.sat_pos <= add_pos;
        bus.sat_neg <= add_neg;
      end else if (state == RESP && bus.ack) begin
        bus.vld     <= 1'b0;
      end
    end
  end

`ifdef SAT_CNT_EN
  generate
    if (1) begin : g_sat_cnt
      // Sticky saturation-event counters, bumped as a result is registered.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sat_cnt0 <= '0;
          sat_cnt1 <= '0;
        end else if (state == CALC && (add_pos || add_neg)) begin
          if (op_id) begin
            if (sat_cnt1 != {CNT_W{1'b1}}) sat_cnt1 <= sat_cnt1 + 1'b1;
          end else begin
            if (sat_cnt0 != {CNT_W{1'b1}}) sat_cnt0 <= sat_cnt0 + 1'b1;
          end
        end
      end
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_sat_add_arb.sv
// ============================================================================
// Module   : tb_sat_add_arb
// Purpose  : Self-checking bench for sat_add_arb: vector table of single
//            operations plus hand-written arbitration, stall and reset
//            sequences. Counter sequence is present when SAT_CNT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sat_add_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  sat_add_arb_if bus();

`ifdef SAT_CNT_EN
  logic [1:0] sat_cnt0;
  logic [1:0] sat_cnt1;
  sat_add_arb #(.CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sat_cnt0 (sat_cnt0),
    .sat_cnt1 (sat_cnt1)
  );
`else
  sat_add_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        pos;
    logic        neg;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete operation from an idle DUT, checking latency and outputs.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ep, input logic en,
                       input string tag);
    int   cyc;
    logic got;
    @(negedge clk);
    if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      got = id ? bus.gnt1 : bus.gnt0;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_gnt"}, 32'(got), 32'd1);
    check({tag, "_gnt_lat"}, 32'(cyc), 32'd1);
    @(posedge clk); #1;
    check({tag, "_vld"}, 32'(bus.vld), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_flags"}, {30'd0, bus.sat_pos, bus.sat_neg}, {30'd0, ep, en});
    check({tag, "_vld_id"}, 32'(bus.vld_id), 32'(id));
    check({tag, "_gnt_low"}, {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    check({tag, "_vld_clr"}, 32'(bus.vld), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic gid;

    vecs[0] = '{1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h7000, 16'h1000, 16'h7FFF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 16'h4000, 16'h3FFF, 16'h7FFF, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'hFFFE, 16'hFFFF, 16'hFFFD, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h8001, 16'hFFFF, 16'h8000, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0};

    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    bus.ack  = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_vld", 32'(bus.vld), 32'd0);
    check("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {30'd0, bus.sat_pos, bus.sat_neg}, 32'd0);
    check("rst_vld_id", 32'(bus.vld_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table (T1, T2 and further arithmetic corners)
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res,
            vecs[i].pos, vecs[i].neg, $sformatf("v%0d", i));
    end

    // T3: both requesters held after reset -> 0,1,0,1
    apply_reset();
    bus.a0 = 16'h0001; bus.b0 = 16'h0002;
    bus.a1 = 16'h0010; bus.b1 = 16'h0020;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!(bus.gnt0 || bus.gnt1) && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("t3_gnt_seen%0d", k), {31'd0, bus.gnt0 | bus.gnt1}, 32'd1);
      check($sformatf("t3_gnt_excl%0d", k), {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      gid = bus.gnt1;
      check($sformatf("t3_order%0d", k), 32'(gid), 32'(k % 2));
      @(posedge clk); #1;
      check($sformatf("t3_vld_id%0d", k), 32'(bus.vld_id), 32'(k % 2));
      check($sformatf("t3_result%0d", k), 32'(bus.result),
            (k % 2) ? 32'h0030 : 32'h0003);
      bus.ack = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // T4: stall in RESP with req0 pulsing
    @(negedge clk);
    bus.req1 = 1'b1; bus.a1 = 16'h0100; bus.b1 = 16'h0200;
    cyc = 0;
    while (!bus.gnt1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t4_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      bus.req0 = i[0];
      bus.a0   = 16'h1111;
      bus.b0   = 16'h2222;
      @(posedge clk); #1;
      check($sformatf("t4_hold%0d", i),
            {13'd0, bus.vld, bus.vld_id, bus.result, bus.gnt0, bus.gnt1},
            {13'd0, 1'b1, 1'b1, 16'h0300, 1'b0, 1'b0});
    end
    bus.req0 = 1'b0;
    bus.ack  = 1'b1;
    @(posedge clk); #1;
    bus.ack  = 1'b0;
    check("t4_vld_clr", 32'(bus.vld), 32'd0);
    @(posedge clk); #1;
    check("t4_no_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);

    // T5: asynchronous reset while in CALC
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 16'h0005; bus.b0 = 16'h0006;
    cyc = 0;
    while (!bus.gnt0 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", 32'(bus.vld), 32'd0);
    check("t5_rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    check("t5_rst_result", 32'(bus.result), 32'd0);
    check("t5_rst_flags", {30'd0, bus.sat_pos, bus.sat_neg}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_rst_hold_vld", 32'(bus.vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, "t5_after");

`ifdef SAT_CNT_EN
    // T6: sticky 2-bit saturation counter on requester 1
    apply_reset();
    check("t6_cnt1_rst", 32'(sat_cnt1), 32'd0);
    for (int k = 0; k < 5; k++) begin
      do_op(1'b1, 16'h7000, 16'h1000, 16'h7FFF, 1'b1, 1'b0, $sformatf("t6_op%0d", k));
      check($sformatf("t6_cnt1_%0d", k), 32'(sat_cnt1), (k >= 2) ? 32'd3 : 32'(k + 1));
      check($sformatf("t6_cnt0_%0d", k), 32'(sat_cnt0), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
